// File: rtl/upsample_stuff.sv
// Zero-stuffing rate expander feeding interp_filt: buffers input-rate samples and
// emits one output-rate sample per en strobe. Build option: UPSAMPLE_HOLD_EN (zero-order hold).
module upsample_stuff #(
  parameter int DATA_WIDTH = 5,
  parameter int UP_FACTOR  = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int PW = (UP_FACTOR > 1) ? $clog2(UP_FACTOR) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid,
  output logic [PW-1:0]                out_phase,
  output logic                         underrun,
  output logic                         underrun_sticky,
  input  logic                         clr_status
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(UP_FACTOR - 1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]                wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]                count_reg, count_next;
  logic [PW-1:0]                phase_reg, phase_next;
  logic signed [DATA_WIDTH-1:0] out_reg, out_next;
  logic                         out_valid_reg, out_valid_next;
  logic [PW-1:0]                out_phase_reg, out_phase_next;
  logic                         underrun_reg, underrun_next;
  logic                         sticky_reg, sticky_next;

  logic fifo_empty;
  logic push;
  logic pop;

  // in_ready depends on the registered count only, so a same-edge pop never opens a slot.
  assign in_ready   = (count_reg != COUNT_FULL) && rst;
  assign fifo_empty = (count_reg == '0);
  assign push       = in_valid && in_ready;
  assign pop        = en && (phase_reg == '0) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    phase_next     = phase_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    out_phase_next = out_phase_reg;
    underrun_next  = 1'b0;
    if (en) begin
      phase_next     = (phase_reg == PHASE_LAST) ? '0 : phase_reg + PW'(1);
      out_valid_next = 1'b1;
      out_phase_next = phase_reg;
      if (phase_reg == '0) begin
        if (!fifo_empty) begin
          out_next = mem[rd_ptr_reg];
        end else begin
          out_next      = '0;
          underrun_next = 1'b1;
        end
      end else begin
`ifdef UPSAMPLE_HOLD_EN
        // out still carries this frame's phase-0 value (0 after an underrun).
        out_next = out_reg;
`else
        out_next = '0;
`endif
      end
    end
    // A new underrun outranks a simultaneous clear.
    sticky_next = sticky_reg;
    if (underrun_next) begin
      sticky_next = 1'b1;
    end else if (clr_status) begin
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      phase_reg     <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_phase_reg <= '0;
      underrun_reg  <= 1'b0;
      sticky_reg    <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      phase_reg     <= phase_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      out_phase_reg <= out_phase_next;
      underrun_reg  <= underrun_next;
      sticky_reg    <= sticky_next;
    end
  end

  assign out             = out_reg;
  assign out_valid       = out_valid_reg;
  assign out_phase       = out_phase_reg;
  assign underrun        = underrun_reg;
  assign underrun_sticky = sticky_reg;

endmodule

// File: tb/tb_upsample_stuff.sv
// Directed bench for upsample_stuff (DATA_WIDTH=5, UP_FACTOR=4, FIFO_DEPTH=2);
// expectations follow UPSAMPLE_HOLD_EN when the bench is built with it.
module tb_upsample_stuff;

`ifdef UPSAMPLE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic signed [4:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [4:0] out;
  logic              out_valid;
  logic [1:0]        out_phase;
  logic              underrun;
  logic              underrun_sticky;
  logic              clr_status = 1'b0;

  int vecs = 0;
  int errs = 0;

  upsample_stuff #(.DATA_WIDTH(5), .UP_FACTOR(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_phase(out_phase),
    .underrun(underrun), .underrun_sticky(underrun_sticky), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  // Expected out for a frame whose phase-0 value is fval.
  function automatic logic signed [4:0] exp_out(input logic signed [4:0] fval, input int ph);
    return (ph == 0 || HOLD) ? fval : 5'sd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; clr_status = 1'b0;
    #4;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    vecs++;
    if ({out, out_phase, out_valid, underrun, underrun_sticky, in_ready} !== 11'b0) begin
      errs++;
      $display("FAIL reset_state: out=%0d ph=%0d v=%0b u=%0b s=%0b rdy=%0b, want all 0",
               out, out_phase, out_valid, underrun, underrun_sticky, in_ready);
    end
    rst = 1'b1;
    cyc();
    vecs++;
    if ({out_valid, underrun, in_ready} !== 3'b001) begin
      errs++;
      $display("FAIL reset_release: v=%0b u=%0b rdy=%0b, want v=0 u=0 rdy=1",
               out_valid, underrun, in_ready);
    end
  endtask

  task automatic test_single();
    logic signed [4:0] fval, eo;
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 5'sd3;
    cyc();
    in_valid = 1'b0;
    vecs++;
    if ({out, out_phase, out_valid, underrun, underrun_sticky} !== {5'sd0, 2'd0, 3'b111}) begin
      errs++;
      $display("FAIL single_same_edge: out=%0d ph=%0d v=%0b u=%0b s=%0b, want 0 0 1 1 1",
               out, out_phase, out_valid, underrun, underrun_sticky);
    end
    for (int i = 1; i < 8; i++) begin
      cyc();
      fval = (i < 4) ? 5'sd0 : 5'sd3;
      eo = exp_out(fval, i % 4);
      vecs++;
      if ({out, out_phase, out_valid, underrun} !== {eo, 2'(i % 4), 2'b10}) begin
        errs++;
        $display("FAIL single[%0d]: out=%0d ph=%0d v=%0b u=%0b, want out=%0d ph=%0d v=1 u=0",
                 i, out, out_phase, out_valid, underrun, eo, i % 4);
      end
    end
  endtask

  // Preload a, b with en=0, then stream with c offered until accepted.
  task automatic run_three(input string name, input logic signed [4:0] a,
                           input logic signed [4:0] b, input logic signed [4:0] c);
    logic signed [4:0] fr [4];
    logic signed [4:0] eo;
    fr = '{a, b, c, 5'sd0};
    do_reset();
    en = 1'b0; in_valid = 1'b1; in_data = a;
    cyc();
    in_data = b;
    cyc();
    in_data = c;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s_full: in_ready=%0b, want 0", name, in_ready);
    end
    cyc();
    vecs++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errs++;
      $display("FAIL %s_stall: in_ready=%0b out_valid=%0b, want 0 0", name, in_ready, out_valid);
    end
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      if (i == 0) begin
        vecs++;
        if (in_ready !== 1'b1) begin
          errs++;
          $display("FAIL %s_ready_after_pop: in_ready=%0b, want 1", name, in_ready);
        end
      end
      if (i == 1) in_valid = 1'b0;
      eo = exp_out(fr[i / 4], i % 4);
      vecs++;
      if ({out, out_phase, underrun} !== {eo, 2'(i % 4), (i == 12)}) begin
        errs++;
        $display("FAIL %s[%0d]: out=%0d ph=%0d u=%0b, want out=%0d ph=%0d u=%0b",
                 name, i, out, out_phase, underrun, eo, i % 4, i == 12);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_three("b2b", 5'sd1, 5'sd2, 5'sd3);
  endtask

  task automatic test_backpressure();
    run_three("bp", 5'sd7, 5'sd8, 5'sd9);
  endtask

  task automatic test_underrun();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      vecs++;
      if ({out, out_phase, underrun, underrun_sticky} !== {5'sd0, 2'(i % 4), (i % 4 == 0), 1'b1}) begin
        errs++;
        $display("FAIL underrun[%0d]: out=%0d ph=%0d u=%0b s=%0b, want 0 %0d %0b 1",
                 i, out, out_phase, underrun, underrun_sticky, i % 4, i % 4 == 0);
      end
    end
    en = 1'b0; clr_status = 1'b1;
    cyc();
    vecs++;
    if ({underrun, underrun_sticky, out_phase} !== 4'b0011) begin
      errs++;
      $display("FAIL clr_alone: u=%0b s=%0b ph=%0d, want u=0 s=0 ph=3",
               underrun, underrun_sticky, out_phase);
    end
    en = 1'b1;
    cyc();
    clr_status = 1'b0;
    vecs++;
    if ({underrun, underrun_sticky} !== 2'b11) begin
      errs++;
      $display("FAIL clr_vs_set: u=%0b s=%0b, want 1 1", underrun, underrun_sticky);
    end
  endtask

  task automatic test_en_gaps();
    logic signed [4:0] eo;
    do_reset();
    en = 1'b0; in_valid = 1'b1; in_data = 5'sd5;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      cyc();
      eo = exp_out(5'sd5, i / 2);
      vecs++;
      if ({out, out_phase, out_valid, underrun, underrun_sticky} !== {eo, 2'(i / 2), 3'b100}) begin
        errs++;
        $display("FAIL en_gap[%0d]: out=%0d ph=%0d v=%0b u=%0b s=%0b, want out=%0d ph=%0d v=1 u=0 s=0",
                 i, out, out_phase, out_valid, underrun, underrun_sticky, eo, i / 2);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b0; in_valid = 1'b1; in_data = 5'sd1;
    cyc();
    in_data = 5'sd2;
    cyc();
    en = 1'b1; in_data = 5'sd3;
    cyc();
    cyc();
    in_valid = 1'b0;
    vecs++;
    if ({in_ready, out_phase} !== 3'b001) begin
      errs++;
      $display("FAIL pre_async: in_ready=%0b ph=%0d, want 0 1", in_ready, out_phase);
    end
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if ({out, out_valid, out_phase, underrun, underrun_sticky, in_ready} !== 11'b0) begin
      errs++;
      $display("FAIL async_reset: out=%0d v=%0b ph=%0d u=%0b s=%0b rdy=%0b, want all 0",
               out, out_valid, out_phase, underrun, underrun_sticky, in_ready);
    end
    cyc();
    rst = 1'b1;
    cyc();
    vecs++;
    if ({out, out_phase, out_valid, underrun, underrun_sticky} !== {5'sd0, 2'd0, 3'b111}) begin
      errs++;
      $display("FAIL post_reset_slot: out=%0d ph=%0d v=%0b u=%0b s=%0b, want 0 0 1 1 1",
               out, out_phase, out_valid, underrun, underrun_sticky);
    end
    cyc();
    vecs++;
    if ({out, out_phase, underrun} !== {5'sd0, 2'd1, 1'b0}) begin
      errs++;
      $display("FAIL post_reset_next: out=%0d ph=%0d u=%0b, want 0 1 0", out, out_phase, underrun);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_backpressure();
    test_en_gaps();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/upsample_stuff.md
Name: upsample_stuff

Overview:
- Rate-expansion stage placed directly upstream of interp_filt.
- Accepts input-rate samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits one output-rate sample per output-rate strobe: each buffered sample followed by UP_FACTOR-1 zeros (zero-stuffing).
- Its out port drives interp_filt.in; sticky underrun status reports starvation.

Parameters:
DATA_WIDTH, 5, sample width (signed, two's complement); must match interp_filt DATA_WIDTH
UP_FACTOR, 4, interpolation ratio, >=1
FIFO_DEPTH, 2, input buffer entries, >=1

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (0 = in reset)
en  input  1  output-rate strobe; phase advances only when 1
in_data  input  DATA_WIDTH  signed input sample
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept a sample
out  output  DATA_WIDTH  signed zero-stuffed sample, registered
out_valid  output  1  out carries a real stream sample
out_phase  output  $clog2(UP_FACTOR) (min 1)  phase of the sample currently on out
underrun  output  1  one-cycle pulse: phase-0 slot found FIFO empty
underrun_sticky  output  1  latched underrun flag
clr_status  input  1  clears underrun_sticky

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed):
  - out=0, out_valid=0, out_phase=0, underrun=0, underrun_sticky=0.
  - Internal phase=0, FIFO emptied.
  - in_ready forced 0 while rst=0.
- Push: on a clk edge with in_valid&&in_ready, in_data is written to the FIFO tail.
  - in_ready = (count != FIFO_DEPTH) && rst.
  - No combinational path from pop to in_ready: when full, a same-cycle pop does not enable a push.
- Phase counter: increments on each clk edge with en=1 and wraps UP_FACTOR-1 -> 0. Held when en=0.
- On a clk edge with en=1 and phase==0:
  - FIFO non-empty: pop the head; out<=head; underrun<=0.
  - FIFO empty: out<=0; underrun<=1; underrun_sticky<=1.
  - Count is sampled before this edge's push, so a sample pushed on the same edge does not satisfy that slot; it reports underrun.
- On a clk edge with en=1 and phase!=0: out<=0 (stuffed zero); underrun<=0.
- On a clk edge with en=1: out_phase<=phase. out_valid<=1 and stays 1 until reset.
- On a clk edge with en=0: out, out_phase and out_valid hold; underrun<=0.
- Latency: a sample accepted at edge t appears on out at the first en edge with phase==0 strictly after t. Minimum is one cycle.
- Simultaneous push and pop with 0<count<FIFO_DEPTH: both occur; count unchanged; order preserved.
- clr_status with a new underrun on the same edge: set wins, underrun_sticky=1.
- UP_FACTOR=1: every en edge pops; out_phase is always 0; no zeros inserted.
- Data is passed through bit-exact; no scaling, no saturation.

Optional Feature:
Macro UPSAMPLE_HOLD_EN.
- Defined (zero-order hold): on phase!=0 edges, out<=the sample most recently popped, instead of 0. A phase-0 underrun still outputs 0, and the following phases of that frame hold 0.
- Not defined: zero-stuffing exactly as in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
1. Reset release, en=1 every cycle, push 3 once -> out sequence 3,0,0,0 on the first full frame after the push. out_valid=1 from the first en edge. No underrun in that frame.
2. Push 1,2,3 back-to-back, en=1 continuously -> out = 1,0,0,0,2,0,0,0,3,0,0,0. out_phase cycles 0,1,2,3. in_ready never drops below what is needed to keep the FIFO fed.
3. No input, en=1 -> underrun pulses once per 4 cycles, at each phase-0 slot; out=0; underrun_sticky=1. Pulse clr_status alone -> sticky=0. Pulse clr_status on an underrun edge -> sticky stays 1.
4. en=0, push 7,8,9 -> 7 and 8 accepted; in_ready=0 with 9 held on in_data. Set en=1 -> 7 popped at phase 0; 9 accepted on the next edge. Output order is 7,8,9.
5. en pattern 1,0,1,0 with a sample of 5 -> out and out_phase change only on en edges. Output is 5,0,0,0 across 8 cycles, with no extra underrun.
6. Drive rst=0 asynchronously mid-frame at phase 2 with 2 samples buffered -> out=0, out_valid=0, in_ready=0 immediately. After release, the first en edge reports underrun (FIFO empty).
   With UPSAMPLE_HOLD_EN defined, rerun scenario 2 -> out = 1,1,1,1,2,2,2,2,3,3,3,3.
